// File: rtl/mips_seq_ctrl_if.sv
// ============================================================================
// mips_seq_ctrl_if : control/status bundle between sequencer and MIPS datapath
// Revision 1.0
// ============================================================================
`default_nettype none

interface mips_seq_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [5:0]       op;
  logic             zero;
  logic             mem_ack;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             ir_we;
  logic             rf_we;
  logic             rf_wsel;
  logic [5:0]       alu_ctrl;
  logic             mem_req;
  logic             mem_we;
  logic             mem_asel;
  logic             busy;
  logic             halted;
  logic             bus_err;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, op, zero, mem_ack,
    output pc_we, pc_src, ir_we, rf_we, rf_wsel, alu_ctrl,
           mem_req, mem_we, mem_asel, busy, halted, bus_err, illegal,
           instr_count
  );

  modport slave (
    output run, op, zero, mem_ack,
    input  pc_we, pc_src, ir_we, rf_we, rf_wsel, alu_ctrl,
           mem_req, mem_we, mem_asel, busy, halted, bus_err, illegal,
           instr_count
  );
endinterface

`default_nettype wire

// File: rtl/mips_seq_ctrl.sv
// ============================================================================
// mips_seq_ctrl : multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for MIPS core
// Revision 1.0
// ============================================================================
`default_nettype none

module mips_seq_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  mips_seq_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_LW   = 6'd5;
  localparam logic [5:0] OP_SW   = 6'd6;
  localparam logic [5:0] OP_BEQ  = 6'd7;
  localparam logic [5:0] OP_J    = 6'd8;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       tmo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, halted_q, bus_err_q, illegal_q;

  logic       pc_we, ir_we, rf_we, rf_wsel, mem_req, mem_we, mem_asel;
  logic [1:0] pc_src;
  logic [5:0] alu_ctrl;
  logic       illegal_dec, tmo_hit;

  // Control outputs are decoded straight from the state register so an
  // asynchronous reset removes every request/enable in the same cycle.
  always_comb begin
    state_d     = state_q;
    pc_we       = 1'b0;
    pc_src      = 2'd0;
    ir_we       = 1'b0;
    rf_we       = 1'b0;
    rf_wsel     = 1'b0;
    alu_ctrl    = 6'd0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_asel    = 1'b0;
    illegal_dec = 1'b0;
    tmo_hit     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (bus.op)
          OP_NOP:  state_d = S_WB;
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_LW, OP_SW, OP_BEQ, OP_J: state_d = S_EXEC;
          OP_HALT: state_d = S_HALT;
          default: begin
            illegal_dec = 1'b1;
            state_d     = S_HALT;
          end
        endcase
      end
      S_EXEC: begin
        state_d = S_WB;
        case (bus.op)
          OP_ADD: alu_ctrl = 6'd1;
          OP_SUB: alu_ctrl = 6'd2;
          OP_AND: alu_ctrl = 6'd3;
          OP_OR:  alu_ctrl = 6'd4;
          OP_LW, OP_SW: begin
            alu_ctrl = 6'd1;
            state_d  = S_MEM;
          end
          OP_BEQ: begin
            alu_ctrl = 6'd2;
            pc_we    = bus.zero;
            pc_src   = 2'd1;
          end
          OP_J: begin
            pc_we  = 1'b1;
            pc_src = 2'd2;
          end
          default: alu_ctrl = 6'd0;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_asel = 1'b1;
        mem_we   = (bus.op == OP_SW);
        alu_ctrl = 6'd1;
        if (bus.mem_ack) state_d = S_WB;
      end
      S_WB: begin
        rf_we   = (bus.op == OP_ADD) || (bus.op == OP_SUB) ||
                  (bus.op == OP_AND) || (bus.op == OP_OR)  ||
                  (bus.op == OP_LW);
        rf_wsel = (bus.op == OP_LW);
        state_d = bus.run ? S_FETCH : S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // The cycle that would make the wait count reach TIMEOUT aborts to HALT.
    if (mem_req && !bus.mem_ack && (tmo_q == TMO_LAST)) begin
      tmo_hit = 1'b1;
      state_d = S_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tmo_q     <= 8'd0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Outside an unacknowledged access the counter sits at zero, so it is
      // already clear on every entry to FETCH or MEM.
      tmo_q     <= (mem_req && !bus.mem_ack) ? tmo_q + 8'd1 : 8'd0;
      if (state_q == S_WB) cnt_q <= cnt_q + CNT_W'(1);
      busy_q    <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q  <= (state_d == S_HALT);
      bus_err_q <= bus_err_q | tmo_hit;
      illegal_q <= illegal_q | illegal_dec;
    end
  end

  assign bus.pc_we       = pc_we;
  assign bus.pc_src      = pc_src;
  assign bus.ir_we       = ir_we;
  assign bus.rf_we       = rf_we;
  assign bus.rf_wsel     = rf_wsel;
  assign bus.alu_ctrl    = alu_ctrl;
  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;
  assign bus.mem_asel    = mem_asel;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;
  assign bus.bus_err     = bus_err_q;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_seq_ctrl.sv
// ============================================================================
// tb_mips_seq_ctrl : scoreboard bench for the multi-cycle sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mips_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  mips_seq_ctrl_if #(.CNT_W(16)) bus ();
  mips_seq_ctrl_if #(.CNT_W(3))  bus2 ();

  mips_seq_ctrl #(.CNT_W(16), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Narrow counter copy so wrap-around is reachable in a short run.
  mips_seq_ctrl #(.CNT_W(3), .TIMEOUT(15)) dut_w (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  // {pc_we, pc_src, ir_we, rf_we, rf_wsel, alu_ctrl, mem_req, mem_we,
  //  mem_asel, busy, halted, bus_err, illegal}
  localparam logic [18:0] V_IDLE    = 19'd0;
  localparam logic [18:0] V_FWAIT   = {1'b0, 2'd0, 3'b000, 6'd0, 3'b100, 4'b1000};
  localparam logic [18:0] V_FACK    = {1'b1, 2'd0, 3'b100, 6'd0, 3'b100, 4'b1000};
  localparam logic [18:0] V_DEC     = {1'b0, 2'd0, 3'b000, 6'd0, 3'b000, 4'b1000};
  localparam logic [18:0] V_MEM_LW  = {1'b0, 2'd0, 3'b000, 6'd1, 3'b101, 4'b1000};
  localparam logic [18:0] V_MEM_SW  = {1'b0, 2'd0, 3'b000, 6'd1, 3'b111, 4'b1000};
  localparam logic [18:0] V_WB_ALU  = {1'b0, 2'd0, 3'b010, 6'd0, 3'b000, 4'b1000};
  localparam logic [18:0] V_WB_LW   = {1'b0, 2'd0, 3'b011, 6'd0, 3'b000, 4'b1000};
  localparam logic [18:0] V_WB_NONE = V_DEC;
  localparam logic [18:0] V_HALT    = {1'b0, 2'd0, 3'b000, 6'd0, 3'b000, 4'b0100};
  localparam logic [18:0] V_HALT_BE = {1'b0, 2'd0, 3'b000, 6'd0, 3'b000, 4'b0110};
  localparam logic [18:0] V_HALT_IL = {1'b0, 2'd0, 3'b000, 6'd0, 3'b000, 4'b0101};

  typedef struct {
    logic        run;
    logic [5:0]  op;
    logic        zero;
    logic        ack;
    logic [18:0] exp;
    string       nm;
  } ent_t;

  ent_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [18:0] v_exec(logic pcwe, logic [1:0] src, logic [5:0] alu);
    return {pcwe, src, 3'b000, alu, 3'b000, 4'b1000};
  endfunction

  function automatic logic [18:0] obs_vec();
    return {bus.pc_we, bus.pc_src, bus.ir_we, bus.rf_we, bus.rf_wsel,
            bus.alu_ctrl, bus.mem_req, bus.mem_we, bus.mem_asel,
            bus.busy, bus.halted, bus.bus_err, bus.illegal};
  endfunction

  task automatic push(input logic r, input logic [5:0] o, input logic z,
                      input logic a, input logic [18:0] e, input string nm);
    ent_t t;
    t.run = r; t.op = o; t.zero = z; t.ack = a; t.exp = e; t.nm = nm;
    sb_q.push_back(t);
  endtask

  task automatic step(input logic r, input logic [5:0] o, input logic z,
                      input logic a, output logic [18:0] v);
    @(posedge clk);
    #1;
    bus.run = r; bus.op = o; bus.zero = z; bus.mem_ack = a;
    @(negedge clk);
    v = obs_vec();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.run = 1'b0; bus.op = 6'd0; bus.zero = 1'b0; bus.mem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [18:0] v;
    rst_n = 1'b0;
    bus.run = 1'b1; bus.op = 6'd1; bus.zero = 1'b1; bus.mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    v = obs_vec();
    n_checks++;
    if (v !== V_IDLE) $display("FAIL reset_outputs obs=%h exp=%h", v, V_IDLE);
    else n_pass++;
    n_checks++;
    if (bus.instr_count !== 16'd0) $display("FAIL reset_count obs=%0d exp=0", bus.instr_count);
    else n_pass++;
  endtask

  task automatic test_alu();
    logic [18:0] v;
    ent_t e;
    do_reset();
    push(1, 6'd1, 0, 1, V_IDLE, "alu_idle");
    for (int i = 0; i < 3; i++) begin
      push(1, 6'd1, 0, 1, V_FACK,             "alu_fetch");
      push(1, 6'd1, 0, 1, V_DEC,              "alu_decode");
      push(1, 6'd1, 0, 1, v_exec(0, 2'd0, 6'd1), "alu_exec");
      push(1, 6'd1, 0, 1, V_WB_ALU,           "alu_wb");
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      step(e.run, e.op, e.zero, e.ack, v);
      n_checks++;
      if (v !== e.exp) $display("FAIL %s obs=%h exp=%h", e.nm, v, e.exp);
      else n_pass++;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.instr_count !== 16'd3) $display("FAIL alu_count obs=%0d exp=3", bus.instr_count);
    else n_pass++;
  endtask

  task automatic test_lw_sw();
    logic [18:0] v;
    ent_t e;
    do_reset();
    push(1, 6'd5, 0, 1, V_IDLE,                "lw_idle");
    push(1, 6'd5, 0, 1, V_FACK,                "lw_fetch");
    push(1, 6'd5, 0, 0, V_DEC,                 "lw_decode");
    push(1, 6'd5, 0, 0, v_exec(0, 2'd0, 6'd1), "lw_exec");
    push(1, 6'd5, 0, 0, V_MEM_LW,              "lw_mem_wait1");
    push(1, 6'd5, 0, 0, V_MEM_LW,              "lw_mem_wait2");
    push(1, 6'd5, 0, 1, V_MEM_LW,              "lw_mem_ack");
    push(1, 6'd5, 0, 0, V_WB_LW,               "lw_wb");
    push(1, 6'd6, 0, 1, V_FACK,                "sw_fetch");
    push(1, 6'd6, 0, 0, V_DEC,                 "sw_decode");
    push(1, 6'd6, 0, 0, v_exec(0, 2'd0, 6'd1), "sw_exec");
    push(1, 6'd6, 0, 1, V_MEM_SW,              "sw_mem");
    push(0, 6'd6, 0, 0, V_WB_NONE,             "sw_wb");
    push(0, 6'd6, 0, 0, V_IDLE,                "sw_idle");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      step(e.run, e.op, e.zero, e.ack, v);
      n_checks++;
      if (v !== e.exp) $display("FAIL %s obs=%h exp=%h", e.nm, v, e.exp);
      else n_pass++;
    end
    n_checks++;
    if (bus.instr_count !== 16'd2) $display("FAIL lwsw_count obs=%0d exp=2", bus.instr_count);
    else n_pass++;
  endtask

  task automatic test_branch();
    logic [18:0] v;
    ent_t e;
    do_reset();
    push(1, 6'd7, 1, 1, V_IDLE,                "beq_idle");
    push(1, 6'd7, 1, 1, V_FACK,                "beq_t_fetch");
    push(1, 6'd7, 1, 0, V_DEC,                 "beq_t_decode");
    push(1, 6'd7, 1, 0, v_exec(1, 2'd1, 6'd2), "beq_t_exec");
    push(1, 6'd7, 1, 0, V_WB_NONE,             "beq_t_wb");
    push(1, 6'd7, 0, 1, V_FACK,                "beq_n_fetch");
    push(1, 6'd7, 0, 0, V_DEC,                 "beq_n_decode");
    push(1, 6'd7, 0, 0, v_exec(0, 2'd1, 6'd2), "beq_n_exec");
    push(1, 6'd7, 0, 0, V_WB_NONE,             "beq_n_wb");
    push(1, 6'd8, 0, 1, V_FACK,                "j_fetch");
    push(1, 6'd8, 0, 0, V_DEC,                 "j_decode");
    push(1, 6'd8, 0, 0, v_exec(1, 2'd2, 6'd0), "j_exec");
    push(0, 6'd8, 0, 0, V_WB_NONE,             "j_wb");
    push(0, 6'd8, 0, 0, V_IDLE,                "j_idle");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      step(e.run, e.op, e.zero, e.ack, v);
      n_checks++;
      if (v !== e.exp) $display("FAIL %s obs=%h exp=%h", e.nm, v, e.exp);
      else n_pass++;
    end
    n_checks++;
    if (bus.instr_count !== 16'd3) $display("FAIL branch_count obs=%0d exp=3", bus.instr_count);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [18:0] v;
    ent_t e;
    do_reset();
    push(1, 6'd1, 0, 0, V_IDLE, "tmo_idle");
    for (int i = 0; i < 15; i++) push(1, 6'd1, 0, 0, V_FWAIT, "tmo_fetch_wait");
    for (int i = 0; i < 4; i++)  push(i[0], 6'd1, 0, 1, V_HALT_BE, "tmo_halt");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      step(e.run, e.op, e.zero, e.ack, v);
      n_checks++;
      if (v !== e.exp) $display("FAIL %s obs=%h exp=%h", e.nm, v, e.exp);
      else n_pass++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    v = obs_vec();
    n_checks++;
    if (v !== V_IDLE) $display("FAIL tmo_reset_clear obs=%h exp=%h", v, V_IDLE);
    else n_pass++;
  endtask

  task automatic test_illegal();
    logic [18:0] v;
    ent_t e;
    do_reset();
    push(1, 6'd9, 0, 1, V_IDLE,    "ill_idle");
    push(1, 6'd9, 0, 1, V_FACK,    "ill_fetch");
    push(1, 6'd9, 0, 0, V_DEC,     "ill_decode");
    push(1, 6'd9, 0, 1, V_HALT_IL, "ill_halt");
    push(0, 6'd9, 0, 1, V_HALT_IL, "ill_halt_hold");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      step(e.run, e.op, e.zero, e.ack, v);
      n_checks++;
      if (v !== e.exp) $display("FAIL %s obs=%h exp=%h", e.nm, v, e.exp);
      else n_pass++;
    end
    n_checks++;
    if (bus.instr_count !== 16'd0) $display("FAIL ill_count obs=%0d exp=0", bus.instr_count);
    else n_pass++;
    do_reset();
    push(1, 6'd63, 0, 1, V_IDLE, "halt_idle");
    push(1, 6'd63, 0, 1, V_FACK, "halt_fetch");
    push(1, 6'd63, 0, 0, V_DEC,  "halt_decode");
    push(1, 6'd63, 0, 1, V_HALT, "halt_state");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      step(e.run, e.op, e.zero, e.ack, v);
      n_checks++;
      if (v !== e.exp) $display("FAIL %s obs=%h exp=%h", e.nm, v, e.exp);
      else n_pass++;
    end
    n_checks++;
    if (bus.instr_count !== 16'd0) $display("FAIL halt_count obs=%0d exp=0", bus.instr_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid_and_run_drop();
    logic [18:0] v;
    ent_t e;
    do_reset();
    push(1, 6'd6, 0, 1, V_IDLE,                "rm_idle");
    push(1, 6'd6, 0, 1, V_FACK,                "rm_fetch");
    push(1, 6'd6, 0, 0, V_DEC,                 "rm_decode");
    push(1, 6'd6, 0, 0, v_exec(0, 2'd0, 6'd1), "rm_exec");
    push(1, 6'd6, 0, 0, V_MEM_SW,              "rm_mem");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      step(e.run, e.op, e.zero, e.ack, v);
      n_checks++;
      if (v !== e.exp) $display("FAIL %s obs=%h exp=%h", e.nm, v, e.exp);
      else n_pass++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    v = obs_vec();
    n_checks++;
    if (v !== V_IDLE) $display("FAIL rm_async_drop obs=%h exp=%h", v, V_IDLE);
    else n_pass++;

    do_reset();
    push(1, 6'd1, 0, 1, V_IDLE,                "rd_idle");
    push(1, 6'd1, 0, 1, V_FACK,                "rd_fetch");
    push(1, 6'd1, 0, 0, V_DEC,                 "rd_decode");
    push(0, 6'd1, 0, 0, v_exec(0, 2'd0, 6'd1), "rd_exec");
    push(0, 6'd1, 0, 0, V_WB_ALU,              "rd_wb");
    push(0, 6'd1, 0, 1, V_IDLE,                "rd_idle_after");
    push(0, 6'd1, 0, 1, V_IDLE,                "rd_idle_stay");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      step(e.run, e.op, e.zero, e.ack, v);
      n_checks++;
      if (v !== e.exp) $display("FAIL %s obs=%h exp=%h", e.nm, v, e.exp);
      else n_pass++;
    end
    n_checks++;
    if (bus.instr_count !== 16'd1) $display("FAIL rd_count obs=%0d exp=1", bus.instr_count);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [2:0] q[$];
    logic [2:0] exp_c;
    bus2.run = 1'b1; bus2.op = 6'd1; bus2.zero = 1'b0; bus2.mem_ack = 1'b1;
    @(posedge clk);
    #1;
    rst2_n = 1'b1;
    // One idle cycle, then each ADD retires four cycles later.
    for (int k = 1; k <= 9; k++) q.push_back(3'(k));
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      repeat (4) @(posedge clk);
      #1;
      exp_c = q.pop_front();
      n_checks++;
      if (bus2.instr_count !== exp_c)
        $display("FAIL wrap_count_%0d obs=%0d exp=%0d", k, bus2.instr_count, exp_c);
      else n_pass++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.run = 1'b0; bus.op = 6'd0; bus.zero = 1'b0; bus.mem_ack = 1'b0;
    bus2.run = 1'b0; bus2.op = 6'd0; bus2.zero = 1'b0; bus2.mem_ack = 1'b0;
    test_reset();
    test_alu();
    test_lw_sw();
    test_branch();
    test_timeout();
    test_illegal();
    test_reset_mid_and_run_drop();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
